// File: rtl/bsg_irq_axil_pkg.sv
// ============================================================================
// Module      : bsg_irq_axil_pkg
// Description : Shared FSM state encoding and AXI response codes for the
//               interrupt-to-AXI-lite notification scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_irq_axil_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_irq_rr_arb.sv
// ============================================================================
// Module      : bsg_irq_rr_arb
// Description : Combinational round-robin arbiter; the search starts one past
//               the previous grant and wraps around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_irq_rr_arb
    import bsg_irq_axil_pkg::*;
#(
    parameter int REQ_N = 2,
    parameter int IDX_W = 1
) (
    input  logic [REQ_N-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_grant
);

    // First pass covers indices above the last grant, second pass wraps to 0.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        for (int j = 0; j < REQ_N; j++) begin
            if (!o_valid && i_req[j] && (j > int'(i_last))) begin
                o_valid = 1'b1;
                o_grant = IDX_W'(j);
            end
        end
        for (int j = 0; j < REQ_N; j++) begin
            if (!o_valid && i_req[j] && (j <= int'(i_last))) begin
                o_valid = 1'b1;
                o_grant = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_irq_axil_scheduler.sv
// ============================================================================
// Module      : bsg_irq_axil_scheduler
// Description : Turns rising interrupt edges into AXI-lite notification writes,
//               one outstanding at a time, round-robin across sources.
//               Optional BSG_IRQ_AXIL_SCHEDULER_RETRY_EN keeps a source pending
//               after an error response so it is re-sent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_irq_axil_scheduler
    import bsg_irq_axil_pkg::*;
#(
    parameter int                           axil_data_width_p = 32,
    parameter int                           axil_addr_width_p = 32,
    parameter int                           irq_sources_p     = 2,
    parameter logic [axil_addr_width_p-1:0] irq_addr_p        = '0
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [irq_sources_p-1:0]       irq_i,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,

    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,

    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    output logic [irq_sources_p-1:0]       pending_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int IDX_W = idx_width(irq_sources_p);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [irq_sources_p-1:0] r_irq;
    logic [irq_sources_p-1:0] r_pend;
    logic                     r_started;
    logic [IDX_W-1:0]         r_grant;
    logic [IDX_W-1:0]         r_last;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic                     r_again;
    logic                     r_err;

    logic                     w_arb_v;
    logic [IDX_W-1:0]         w_arb_idx;
    logic                     w_arb_take;
    logic                     w_aw_done_nxt;
    logic                     w_w_done_nxt;
    logic                     w_b_fire;
    logic                     w_bad;
    logic                     w_retry_keep;
    logic [irq_sources_p-1:0] w_edge;
    logic [irq_sources_p-1:0] w_grant_oh;
    logic [irq_sources_p-1:0] w_clr;

    // r_started masks the first post-reset sample so lines already high at
    // release must fall and rise again before they count as edges.
    assign w_edge     = irq_i & ~r_irq & {irq_sources_p{r_started}};
    assign w_grant_oh = irq_sources_p'(1) << r_grant;
    assign w_bad      = (m_axil_bresp_i != OKAY);

`ifdef BSG_IRQ_AXIL_SCHEDULER_RETRY_EN
    assign w_retry_keep = w_bad;
`else
    assign w_retry_keep = 1'b0;
`endif

    // A re-edge on the source being served keeps its bit for one more write.
    assign w_clr = (w_b_fire && !r_again && !w_retry_keep) ? w_grant_oh : '0;

    bsg_irq_rr_arb #(
        .REQ_N (irq_sources_p),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (r_pend),
        .i_last  (r_last),
        .o_valid (w_arb_v),
        .o_grant (w_arb_idx)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_arb_take       = 1'b0;
        w_aw_done_nxt    = r_aw_done;
        w_w_done_nxt     = r_w_done;
        w_b_fire         = 1'b0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_v) begin
                    w_arb_take    = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = SEND;
                end
            end
            SEND: begin
                m_axil_awvalid_o = !r_aw_done;
                m_axil_wvalid_o  = !r_w_done;
                w_aw_done_nxt    = r_aw_done | m_axil_awready_i;
                w_w_done_nxt     = r_w_done | m_axil_wready_i;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                m_axil_bready_o = 1'b1;
                if (m_axil_bvalid_i) begin
                    w_b_fire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state   <= IDLE;
            r_irq     <= '0;
            r_pend    <= '0;
            r_started <= 1'b0;
            r_grant   <= '0;
            r_last    <= IDX_W'(irq_sources_p - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_again   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq     <= irq_i;
            r_started <= 1'b1;
            r_pend    <= (r_pend & ~w_clr) | w_edge;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_err     <= w_b_fire && w_bad;
            if (w_arb_take) begin
                r_grant <= w_arb_idx;
                r_again <= 1'b0;
            end else if ((r_state != IDLE) && |(w_edge & w_grant_oh)) begin
                r_again <= 1'b1;
            end
            if (w_b_fire) begin
                r_last <= r_grant;
            end
        end
    end

    assign m_axil_awaddr_o = irq_addr_p + (axil_addr_width_p'(r_grant) << 2);
    assign m_axil_awprot_o = 3'b000;
    assign m_axil_wdata_o  = axil_data_width_p'(r_grant);
    assign m_axil_wstrb_o  = '1;
    assign pending_o       = r_pend;
    assign busy_o          = (r_state != IDLE);
    assign err_o           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bsg_irq_axil_scheduler.sv
// ============================================================================
// Module      : tb_bsg_irq_axil_scheduler
// Description : Randomised and directed bench with a behavioural scoreboard for
//               the interrupt notification scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_irq_axil_scheduler;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [N-1:0] irq;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [N-1:0] pending;
    logic        busy, err;

    bsg_irq_axil_scheduler #(
        .axil_data_width_p (32),
        .axil_addr_width_p (32),
        .irq_sources_p     (N),
        .irq_addr_p        (BASE)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .irq_i            (irq),
        .m_axil_awaddr_o  (awaddr),
        .m_axil_awprot_o  (awprot),
        .m_axil_awvalid_o (awvalid),
        .m_axil_awready_i (awready),
        .m_axil_wdata_o   (wdata),
        .m_axil_wstrb_o   (wstrb),
        .m_axil_wvalid_o  (wvalid),
        .m_axil_wready_i  (wready),
        .m_axil_bresp_i   (bresp),
        .m_axil_bvalid_i  (bvalid),
        .m_axil_bready_o  (bready),
        .pending_o        (pending),
        .busy_o           (busy),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- AXI-lite slave responder ----------------
    int  rmode     = 0;   // 0 random, 1 AW stalled 5 cycles, 2 always ready
    int  bdelay    = -1;  // -1 random 0..2
    bit  force_err = 0;
    bit  rand_err  = 0;
    bit  s_aw, s_w;
    int  s_bstate, s_bwait, s_awcnt;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        s_aw = 0; s_w = 0; s_bstate = 0; s_bwait = 0; s_awcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                s_aw = 0; s_w = 0; s_bstate = 0; s_awcnt = 0;
            end else begin
                if (awvalid && awready) begin s_aw = 1; s_awcnt = 0; end
                else if (awvalid) s_awcnt++;
                if (wvalid && wready) s_w = 1;
                if (s_bstate == 2 && bvalid && bready) begin
                    s_bstate = 0; s_aw = 0; s_w = 0;
                end
                if (s_bstate == 0 && s_aw && s_w) begin
                    s_bstate = 1;
                    s_bwait  = (bdelay < 0) ? int'($urandom_range(0, 2)) : bdelay;
                end
            end
            @(posedge clk);
            #1;
            case (rmode)
                1:       begin awready = (s_awcnt >= 5); wready = 1; end
                2:       begin awready = 1; wready = 1; end
                default: begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
            endcase
            if (s_bstate == 1) begin
                if (s_bwait == 0) begin
                    s_bstate = 2;
                    bvalid   = 1;
                    bresp    = (force_err || (rand_err && $urandom_range(0, 7) == 0)) ? 2'b10 : 2'b00;
                    force_err = 0;
                end else begin
                    s_bwait--;
                end
            end else if (s_bstate == 0) begin
                bvalid = 0;
            end
        end
    end

    // ---------------- behavioural model + monitor ----------------
    logic [N-1:0] m_pend = '0, m_pend_prev = '0, m_irq_prev = '0;
    int           m_last = N - 1;
    bit           m_in = 0, m_again = 0, m_aw = 0, m_w = 0, m_err_exp = 0;
    bit           m_busy_prev = 0, m_rst_prev_n = 1;
    int           exp_q[$];
    logic [31:0]  aw_log[$];
    int           n_err = 0;

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int i = 1; i <= N; i++) begin
            if (p[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] e;
        int  cur;
        bit  bad, keep;
        if (!reset_n) begin
            if (!m_rst_prev_n)
                chk("reset_outputs", {awvalid, wvalid, bready, busy, err, pending}, '0);
            m_pend = '0; m_pend_prev = '0; m_last = N - 1;
            m_in = 0; m_aw = 0; m_w = 0; m_err_exp = 0; m_busy_prev = 0;
            exp_q.delete();
            m_irq_prev = irq;
            m_rst_prev_n = 0;
        end else begin
            chk("pending_o", pending, m_pend);
            chk("err_o", err, m_err_exp);
            if (err) n_err++;
            if (m_rst_prev_n && !m_busy_prev && (m_pend_prev != '0)) begin
                exp_q.push_back(rr_pick(m_pend_prev, m_last));
                m_in = 1; m_again = 0; m_aw = 0; m_w = 0;
            end
            chk("busy_o", busy, m_in);
            chk("awvalid", awvalid, m_in && !m_aw);
            chk("wvalid", wvalid, m_in && !m_w);
            chk("bready", bready, m_in && m_aw && m_w);
            cur = (exp_q.size() > 0) ? exp_q[0] : 0;
            if (awvalid && awready) begin
                chk("awaddr", awaddr, BASE + 32'(cur) * 4);
                chk("awprot", awprot, 3'b000);
                aw_log.push_back(awaddr);
                m_aw = 1;
            end
            if (wvalid && wready) begin
                chk("wdata", wdata, 32'(cur));
                chk("wstrb", wstrb, 4'hF);
                m_w = 1;
            end
            e = m_rst_prev_n ? (irq & ~m_irq_prev) : '0;
            if (m_in && e[cur]) m_again = 1;
            m_err_exp   = 0;
            m_pend_prev = m_pend;
            if (bvalid && bready && m_in) begin
                bad  = (bresp != 2'b00);
                keep = m_again;
`ifdef BSG_IRQ_AXIL_SCHEDULER_RETRY_EN
                keep = keep || bad;
`endif
                m_err_exp = bad;
                if (!keep) m_pend[cur] = 1'b0;
                m_last = cur;
                m_in   = 0;
                void'(exp_q.pop_front());
            end
            m_pend       = m_pend | e;
            m_busy_prev  = busy;
            m_irq_prev   = irq;
            m_rst_prev_n = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        cyc(3);
        reset_n = 1;
        cyc(1);
    endtask

    task automatic wait_idle();
        int t = 0;
        cyc(2);
        while (!(busy == 0 && pending == '0) && t < 400) begin
            cyc(1);
            t++;
        end
        if (t >= 400) chk("idle_timeout", 64'(t), 0);
        cyc(2);
    endtask

    function automatic int count_addr(input logic [31:0] a);
        int c = 0;
        foreach (aw_log[i]) if (aw_log[i] == a) c++;
        return c;
    endfunction

    initial begin
        int t;
        reset_n = 0;
        irq     = '0;
        do_reset();

        // single source: irq[2]
        aw_log.delete();
        irq[2] = 1; cyc(2); irq[2] = 0;
        wait_idle();
        chk("single_write_count", aw_log.size(), 1);
        chk("single_write_addr", (aw_log.size() > 0) ? aw_log[0] : 32'h0, 32'h1008);

        // simultaneous sources from a fresh reset: order 0,1,3
        do_reset();
        aw_log.delete();
        irq = 4'b1011; cyc(2); irq = '0;
        wait_idle();
        chk("rr_count", aw_log.size(), 3);
        if (aw_log.size() == 3) begin
            chk("rr_order0", aw_log[0], 32'h1000);
            chk("rr_order1", aw_log[1], 32'h1004);
            chk("rr_order2", aw_log[2], 32'h100C);
        end

        // AW stalled with W ready, then both ready together
        rmode = 1; aw_log.delete();
        irq[0] = 1; cyc(1); irq[0] = 0;
        wait_idle();
        rmode = 2;
        irq[1] = 1; cyc(1); irq[1] = 0;
        wait_idle();
        chk("stall_writes", aw_log.size(), 2);

        // re-pulse own source during RESP
        rmode = 0; bdelay = 3; aw_log.delete();
        irq[1] = 1; cyc(1); irq[1] = 0;
        t = 0;
        while (!bready && t < 100) begin cyc(1); t++; end
        if (t >= 100) chk("resp_timeout", 64'(t), 0);
        irq[1] = 1; cyc(1); irq[1] = 0;
        wait_idle();
        bdelay = -1;
        chk("merge_writes", count_addr(32'h1004), 2);

        // error response
        aw_log.delete(); n_err = 0; force_err = 1;
        irq[3] = 1; cyc(1); irq[3] = 0;
        wait_idle();
        chk("err_pulses", n_err, 1);
`ifdef BSG_IRQ_AXIL_SCHEDULER_RETRY_EN
        chk("err_rewrites", count_addr(32'h100C), 2);
`else
        chk("err_rewrites", count_addr(32'h100C), 1);
`endif

        // reset during SEND with irq[0] held high
        rmode = 1;
        irq[0] = 1;
        t = 0;
        while (!busy && t < 50) begin cyc(1); t++; end
        if (t >= 50) chk("busy_timeout", 64'(t), 0);
        reset_n = 0; cyc(2); reset_n = 1;
        aw_log.delete();
        cyc(20);
        chk("no_write_after_reset", aw_log.size(), 0);
        chk("no_pending_after_reset", pending, '0);
        irq[0] = 0; cyc(2); irq[0] = 1; cyc(2);
        wait_idle();
        chk("write_after_toggle", aw_log.size(), 1);
        irq[0] = 0;
        rmode = 0;
        wait_idle();

        // randomised traffic
        rand_err = 1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, N - 1)] ^= 1'b1;
            cyc(1);
        end
        irq = '0;
        wait_idle();
        rand_err = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsg_irq_axil_scheduler.md
BSG_IRQ_AXIL_SCHEDULER -- requirements
Module: bsg_irq_axil_scheduler

Interface
REQ-001 Parameter axil_data_width_p, default 32: AXI-lite data width; SHALL be 32 or 64.
REQ-002 Parameter axil_addr_width_p, default 32: AXI-lite address width.
REQ-003 Parameter irq_sources_p, default 2: number of interrupt sources; SHALL be 1..32.
REQ-004 Parameter irq_addr_p, default 32'h0: base address of the notification window.
REQ-005 clk_i  in  1  sole clock; all logic SHALL be rising-edge.
REQ-006 reset_n_i  in  1  reset, synchronous, active-low.
REQ-007 irq_i  in  irq_sources_p  level interrupt lines, synchronous to clk_i.
REQ-008 m_axil_awaddr_o / m_axil_awprot_o / m_axil_awvalid_o  out  addr_width / 3 / 1  write address; m_axil_awready_i  in  1.
REQ-009 m_axil_wdata_o / m_axil_wstrb_o / m_axil_wvalid_o  out  data_width / data_width/8 / 1  write data; m_axil_wready_i  in  1.
REQ-010 m_axil_bresp_i  in  2, m_axil_bvalid_i  in  1, m_axil_bready_o  out  1  write response.
REQ-011 pending_o  out  irq_sources_p  pending-notification bits.
REQ-012 busy_o  out  1  high when the FSM is not in IDLE.
REQ-013 err_o  out  1  one-cycle pulse on a non-OKAY bresp.

Function
REQ-014 Each source SHALL have a registered copy of irq_i; a 0->1 transition SHALL set its pending bit one cycle after irq_i rises.
REQ-015 A set and a clear of the same pending bit in one cycle SHALL leave it set.
REQ-016 FSM states SHALL be IDLE, SEND, and RESP; only one write SHALL be outstanding at any time.
REQ-017 IDLE: if any pending bit is set, the arbiter SHALL grant one source, latch its index, and enter SEND next cycle with awvalid=wvalid=1.
REQ-018 The arbiter SHALL be round-robin: search starts at (last_grant+1) mod irq_sources_p and wraps; after reset last_grant SHALL be irq_sources_p-1, so source 0 has first priority.
REQ-019 awaddr SHALL be irq_addr_p + (grant_index<<2), truncated to axil_addr_width_p; awprot SHALL be 3'b000.
REQ-020 wdata SHALL be grant_index zero-extended; wstrb SHALL be all ones.
REQ-021 SEND: AW and W SHALL complete independently. Each valid drops the cycle after its own handshake and is not re-asserted. SEND SHALL exit to RESP only when both have completed, including when both complete in the same cycle.
REQ-022 awaddr, wdata and the grant index SHALL hold stable while the corresponding valid is high.
REQ-023 RESP: bready=1; bready SHALL be 0 in all other states. On bvalid, the granted pending bit is cleared (unless REQ-030 applies), err_o pulses if bresp!=2'b00, last_grant updates, and the FSM returns to IDLE.
REQ-024 No new arbitration SHALL occur in the RESP-exit cycle; minimum spacing SHALL be 1 IDLE cycle between bursts.
REQ-025 An edge that arrives during service of the same source SHALL be merged: the pending bit is set and remains set after the clear (REQ-015), so exactly one further write is issued.
REQ-026 Edges on other sources SHALL be captured at any time without loss.

Reset
REQ-027 While reset_n_i=0 at a clock edge: FSM=IDLE; pending, irq register, and handshake-done flags = 0; last_grant = irq_sources_p-1.
REQ-028 During and after reset: awvalid=wvalid=bready=0, busy_o=0, err_o=0, pending_o=0.
REQ-029 Reset mid-transaction SHALL abandon the transfer; lines that are high when reset releases SHALL NOT generate edges until they fall and rise again.

Configuration
REQ-030 With BSG_IRQ_AXIL_SCHEDULER_RETRY_EN defined, a non-OKAY bresp SHALL leave the pending bit set so the source is re-arbitrated after the round-robin pointer advances; without the macro, the bit SHALL be cleared regardless of bresp. err_o SHALL pulse in both cases.

Structure
REQ-031 A shared package bsg_irq_axil_pkg SHALL hold the FSM state enum (IDLE, SEND, RESP) and the AXI response constants (OKAY=2'b00, SLVERR=2'b10).
REQ-032 The round-robin arbiter SHALL be one sub-module, bsg_irq_rr_arb; edge detection and pending storage stay inline.

Verification
REQ-033 With irq_sources_p=4 and irq_addr_p=32'h1000, pulse irq_i[2] -> one write with awaddr=32'h1008 and wdata=2; pending_o[2] clears on bvalid.
REQ-034 Raise irq_i[0], irq_i[1], and irq_i[3] in the same cycle -> writes are issued in order 0x1000, 0x1004, 0x100C, and only one transaction is outstanding at a time.
REQ-035 Hold awready=0 for 5 cycles with wready=1 -> W completes first, AW completes later, then exactly one RESP phase follows; repeat with both ready in the same cycle.
REQ-036 Re-pulse irq_i[1] during its own RESP phase -> exactly one extra write to 0x1004.
REQ-037 Return bresp=2'b10 -> err_o pulses once; the source is rewritten only when the macro is defined.
REQ-038 Drop reset_n_i in SEND while irq_i[0] is held high -> all outputs are 0 and no write is issued until irq_i[0] is toggled.
